// File: rtl/fd_skid_latch.sv
// Fetch/decode pipeline latch with a one-entry skid buffer. Accepted beats appear one cycle later and in_ready is registered.
// Defining FD_SKID_LATCH_STATS_EN adds saturating stall_cnt/flush_cnt outputs.
module fd_skid_latch #(
  parameter int PC_W   = 32,
  parameter int INSN_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INSN_W-1:0] in_insn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
`ifdef FD_SKID_LATCH_STATS_EN
  output logic [INSN_W-1:0] out_insn,
  output logic [15:0]       stall_cnt,
  output logic [7:0]        flush_cnt
`else
  output logic [INSN_W-1:0] out_insn
`endif
);

  logic              m_valid_q, m_valid_d;
  logic [PC_W-1:0]   m_pc_q, m_pc_d;
  logic [INSN_W-1:0] m_insn_q, m_insn_d;
  logic              s_valid_q, s_valid_d;
  logic [PC_W-1:0]   s_pc_q, s_pc_d;
  logic [INSN_W-1:0] s_insn_q, s_insn_d;
  logic              in_fire, out_fire;

  // in_ready comes straight from a flop, so there is no out_ready -> in_ready path
  assign in_ready  = !s_valid_q;
  assign out_valid = m_valid_q;
  assign out_pc    = m_valid_q ? m_pc_q : '0;
  assign out_insn  = m_valid_q ? m_insn_q : '0;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = m_valid_q & out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_pc_d    = m_pc_q;
    m_insn_d  = m_insn_q;
    s_valid_d = s_valid_q;
    s_pc_d    = s_pc_q;
    s_insn_d  = s_insn_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q) begin
      if (in_fire) begin
        m_valid_d = 1'b1;
        m_pc_d    = in_pc;
        m_insn_d  = in_insn;
      end
    end else if (!s_valid_q) begin
      if (in_fire && out_fire) begin
        m_pc_d   = in_pc;
        m_insn_d = in_insn;
      end else if (in_fire) begin
        s_valid_d = 1'b1;
        s_pc_d    = in_pc;
        s_insn_d  = in_insn;
      end else if (out_fire) begin
        m_valid_d = 1'b0;
      end
    end else if (out_fire) begin
      // Skid drains into main; in_fire cannot happen while full
      m_pc_d    = s_pc_q;
      m_insn_d  = s_insn_q;
      s_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      m_valid_q <= 1'b0;
      m_pc_q    <= '0;
      m_insn_q  <= '0;
      s_valid_q <= 1'b0;
      s_pc_q    <= '0;
      s_insn_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_pc_q    <= m_pc_d;
      m_insn_q  <= m_insn_d;
      s_valid_q <= s_valid_d;
      s_pc_q    <= s_pc_d;
      s_insn_q  <= s_insn_d;
    end
  end

`ifdef FD_SKID_LATCH_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (m_valid_q && !out_ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    // Only flushes that actually discard something are counted
    if (flush && (m_valid_q || s_valid_q) && flush_cnt_q != 8'hFF)
      flush_cnt_d = flush_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
`endif

endmodule
